// File: rtl/conv_route_scheduler.sv
// conv_route_scheduler
//   Walks one convolution layer channel by channel. For each channel it sets
//   the router's start address in the shared input buffer, launches the router,
//   and waits for it to finish. It also owns the single buffer read port: the
//   router always wins, and a host/debug reader is served only while no job
//   is running.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   start                 job request, only sampled while idle
//   baseAddr              buffer address of channel 0
//   inputWidth            square input edge
//   numChannels           number of channels in the job
//   busy / done / error   job status (done is a one-cycle pulse)
//   channel               index of the channel being routed
//   routeEn               one-cycle launch pulse to the router
//   routeStartAddr        router start address
//   routeInputWidth       latched input width for the router
//   routeFinished         router finished flag (sticky)
//   routeReadEn/Addr      router buffer read request
//   hostReq/hostAddr      host read request
//   hostGnt               host read granted this cycle
//   bufReadEn/Addr        buffer read port
module conv_route_scheduler #(
    parameter int Depth       = 32,
    parameter int DataWidth   = 8,
    parameter int KernelSize  = 3,
    parameter int MaxChannels = 4,
    parameter int AddrWidth   = $clog2(Depth),
    parameter int ChWidth     = $clog2(MaxChannels + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [AddrWidth-1:0] baseAddr,
    input  logic [AddrWidth-1:0] inputWidth,
    input  logic [ChWidth-1:0]   numChannels,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [ChWidth-1:0]   channel,
    output logic                 routeEn,
    output logic [AddrWidth-1:0] routeStartAddr,
    output logic [AddrWidth-1:0] routeInputWidth,
    input  logic                 routeFinished,
    input  logic                 routeReadEn,
    input  logic [AddrWidth-1:0] routeReadAddr,
    input  logic                 hostReq,
    input  logic [AddrWidth-1:0] hostAddr,
    output logic                 hostGnt,
    output logic                 bufReadEn,
    output logic [AddrWidth-1:0] bufReadAddr
);

    // Wide enough that base + channels * width^2 cannot wrap.
    localparam int FootWidth = 2 * AddrWidth + ChWidth;

    // Catch nonsensical parameter sets while the design is being built.
    if (DataWidth < 1 || KernelSize < 1 || MaxChannels < 1) begin : g_param_check
        $error("conv_route_scheduler: DataWidth, KernelSize and MaxChannels must be positive");
    end

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        LAUNCH,
        ARM,
        RUN,
        NEXT,
        DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [AddrWidth-1:0]   base_q;
    logic [ChWidth-1:0]     nch_q;
    logic [AddrWidth-1:0]   stride_q;
    logic [3:0]             wd_cnt_q;

    logic [2*AddrWidth-1:0] area;
    logic [FootWidth-1:0]   footprint;
    logic                   cfg_bad;
    logic                   last_channel;
    logic                   wd_expired;

    assign area      = {{AddrWidth{1'b0}}, routeInputWidth} * {{AddrWidth{1'b0}}, routeInputWidth};
    assign footprint = FootWidth'(base_q) + FootWidth'(nch_q) * FootWidth'(area);

    assign cfg_bad = (nch_q == '0)
                  || (nch_q > ChWidth'(MaxChannels))
                  || (routeInputWidth < AddrWidth'(KernelSize))
                  || (footprint > FootWidth'(Depth));

    assign last_channel = (channel == nch_q - ChWidth'(1));

    // Eighth consecutive ARM cycle with the finished flag still up: the
    // router never re-initialized, so give up on the job.
    assign wd_expired = routeFinished && (wd_cnt_q == 4'd7);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every output of this block gets a default first; otherwise a path
    // that leaves one unassigned would infer a latch.
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        routeEn = 1'b0;
        unique case (state_q)
            IDLE:   if (start) state_d = CHECK;
            CHECK:  begin
                busy    = 1'b1;
                state_d = cfg_bad ? DONE : LAUNCH;
            end
            LAUNCH: begin
                busy    = 1'b1;
                routeEn = 1'b1;
                state_d = ARM;
            end
            ARM:    begin
                busy = 1'b1;
                if (!routeFinished)  state_d = RUN;
                else if (wd_expired) state_d = DONE;
            end
            RUN:    begin
                busy = 1'b1;
                if (routeFinished) state_d = NEXT;
            end
            NEXT:   begin
                busy    = 1'b1;
                state_d = last_channel ? DONE : LAUNCH;
            end
            DONE:   begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_q          <= '0;
            nch_q           <= '0;
            stride_q        <= '0;
            wd_cnt_q        <= '0;
            error           <= 1'b0;
            channel         <= '0;
            routeStartAddr  <= '0;
            routeInputWidth <= '0;
        end else begin
            unique case (state_q)
                IDLE: if (start) begin
                    base_q          <= baseAddr;
                    routeInputWidth <= inputWidth;
                    nch_q           <= numChannels;
                    error           <= 1'b0;
                end
                CHECK: begin
                    if (cfg_bad) begin
                        error <= 1'b1;
                    end else begin
                        channel        <= '0;
                        routeStartAddr <= base_q;
                        // A passing footprint check bounds width^2 by Depth.
                        stride_q       <= area[AddrWidth-1:0];
                    end
                end
                LAUNCH: wd_cnt_q <= '0;
                ARM: begin
                    wd_cnt_q <= wd_cnt_q + 4'd1;
                    if (wd_expired) error <= 1'b1;
                end
                NEXT: if (!last_channel) begin
                    channel        <= channel + ChWidth'(1);
                    routeStartAddr <= routeStartAddr + stride_q;
                end
                default: ;
            endcase
        end
    end

    // Router owns the read port whenever it asks; the host only gets idle
    // cycles outside of a job.
    assign hostGnt     = hostReq && !routeReadEn && !busy;
    assign bufReadEn   = routeReadEn || hostGnt;
    assign bufReadAddr = routeReadEn ? routeReadAddr : hostAddr;

endmodule
